// File: rtl/set_assoc_cache_pkg.sv
// Shared types and byte-lane helpers for the set-associative cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_e;

  function automatic logic [31:0] mask_expand(input logic [3:0] mask);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{mask[b]}};
    return m;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  mask);
    logic [31:0] m;
    m = mask_expand(mask);
    return (old_w & ~m) | (new_w & m);
  endfunction

endpackage

// File: rtl/set_assoc_cache_victim_sel.sv
// Replacement choice for one set: lowest invalid way first, otherwise the way after the MRU.
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int IDX_W = 1
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [IDX_W-1:0] mru,
  output logic [IDX_W-1:0] victim
);

  always_comb begin
    victim = '0;
    if (WAYS > 1) begin
      victim = IDX_W'((int'(mru) + 1) % WAYS);
      for (int w = WAYS - 1; w >= 0; w--)
        if (!valid[w]) victim = IDX_W'(w);
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// Write-through, write-allocate set-associative cache with NMRU replacement.
// Optional hit/miss counters are enabled with SET_ASSOC_CACHE_PERF_CNT_EN.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int WAYS        = 2,
  parameter int SET_BITS    = 5,
  parameter int OFFSET_BITS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid,
  output logic        o_busy,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [3:0]  i_req_mask,
  input  logic [31:0] i_req_wdata,
  output logic [31:0] o_res_rdata
`ifdef SET_ASSOC_CACHE_PERF_CNT_EN
  ,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count
`endif
);

  localparam int SETS       = 2 ** SET_BITS;
  localparam int WORD_BITS  = OFFSET_BITS - 2;
  localparam int LINE_WORDS = 2 ** WORD_BITS;
  localparam int TAG_BITS   = 32 - SET_BITS - OFFSET_BITS;
  localparam int IDX_W      = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [31:0]         data_q  [WAYS][SETS][LINE_WORDS];
  logic [TAG_BITS-1:0] tag_q   [WAYS][SETS];
  logic [WAYS-1:0]     valid_q [SETS];
  logic [IDX_W-1:0]    mru_q   [SETS];

  state_e               state_q, state_d;
  logic [31:2]          lat_addr;
  logic [3:0]           lat_mask;
  logic [31:0]          lat_wdata;
  logic                 lat_wr;
  logic [IDX_W-1:0]     victim_q, victim_d;
  logic [WORD_BITS:0]   issue_q;
  logic [WORD_BITS-1:0] resp_q;
  logic                 resp_last;

  logic [31:2]          lk_addr;
  logic [TAG_BITS-1:0]  lk_tag;
  logic [SET_BITS-1:0]  lk_set;
  logic [WORD_BITS-1:0] lk_word;
  logic                 hit;
  logic [IDX_W-1:0]     hit_way;
  logic [31:0]          cache_word;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^i_req_addr[1:0];

  // The lookup follows the live request in IDLE and the latched request everywhere else.
  assign lk_addr   = (state_q == IDLE) ? i_req_addr[31:2] : lat_addr;
  assign lk_tag    = lk_addr[31:SET_BITS+OFFSET_BITS];
  assign lk_set    = lk_addr[SET_BITS+OFFSET_BITS-1:OFFSET_BITS];
  assign lk_word   = lk_addr[OFFSET_BITS-1:2];
  assign resp_last = (resp_q == WORD_BITS'(LINE_WORDS - 1));

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_set][w] && (tag_q[w][lk_set] == lk_tag)) begin
        hit     = 1'b1;
        hit_way = IDX_W'(w);
      end
    end
  end

  assign cache_word = data_q[hit_way][lk_set][lk_word];

  cache_victim_sel #(
    .WAYS  (WAYS),
    .IDX_W (IDX_W)
  ) u_victim_sel (
    .valid  (valid_q[lk_set]),
    .mru    (mru_q[lk_set]),
    .victim (victim_d)
  );

  always_comb begin
    state_d     = state_q;
    o_busy      = 1'b0;
    o_mem_ren   = 1'b0;
    o_mem_wen   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_res_rdata = '0;
    case (state_q)
      IDLE: begin
        if (i_req_ren && hit) begin
          o_res_rdata = cache_word & mask_expand(i_req_mask);
        end else if (i_req_ren || i_req_wen) begin
          o_busy  = 1'b1;
          state_d = (i_req_wen && hit) ? WRITE : FILL;
        end
      end
      FILL: begin
        o_busy    = 1'b1;
        o_mem_ren = !issue_q[WORD_BITS];
        if (o_mem_ren)
          o_mem_addr = {lat_addr[31:OFFSET_BITS], issue_q[WORD_BITS-1:0], 2'b00};
        if (i_mem_valid && resp_last)
          state_d = lat_wr ? WRITE : DONE;
      end
      WRITE: begin
        o_busy      = 1'b1;
        o_mem_wen   = 1'b1;
        o_mem_addr  = {lat_addr, 2'b00};
        o_mem_wdata = byte_merge(cache_word, lat_wdata, lat_mask);
        if (i_mem_ready) state_d = DONE;
      end
      DONE: begin
        if (!lat_wr) o_res_rdata = cache_word & mask_expand(lat_mask);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: valid bits, MRU pointers, counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
      issue_q  <= '0;
      resp_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        mru_q[s]   <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (i_req_ren && hit) begin
            mru_q[lk_set] <= hit_way;
          end else if (state_d == FILL) begin
            victim_q                 <= victim_d;
            issue_q                  <= '0;
            resp_q                   <= '0;
            valid_q[lk_set][victim_d] <= 1'b0;
            mru_q[lk_set]            <= victim_d;
          end
        end
        FILL: begin
          if (o_mem_ren && i_mem_ready) issue_q <= issue_q + (WORD_BITS+1)'(1);
          if (i_mem_valid) begin
            resp_q <= resp_q + WORD_BITS'(1);
            if (resp_last) valid_q[lk_set][victim_q] <= 1'b1;
          end
        end
        WRITE: if (i_mem_ready) mru_q[lk_set] <= hit_way;
        default: ;
      endcase
    end
  end

  // Datapath storage: latched request, tags and line data.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (state_q == IDLE && o_busy) begin
        lat_addr  <= i_req_addr[31:2];
        lat_mask  <= i_req_mask;
        lat_wdata <= i_req_wdata;
        lat_wr    <= i_req_wen;
      end
      if (state_q == IDLE && state_d == FILL)
        tag_q[victim_d][lk_set] <= lk_tag;
      if (state_q == FILL && i_mem_valid)
        data_q[victim_q][lk_set][resp_q] <= i_mem_rdata;
      if (state_q == WRITE && i_mem_ready)
        data_q[hit_way][lk_set][lk_word] <= o_mem_wdata;
    end
  end

`ifdef SET_ASSOC_CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == IDLE && (i_req_ren || i_req_wen)) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign o_hit_count  = hit_cnt_q;
  assign o_miss_count = miss_cnt_q;
`endif

endmodule
